// File: rtl/floo_credit_output_port.sv
// floo_credit_output_port
// -----------------------
// Output port of a credit-based NoC router. Several input ports compete
// for one physical link that carries several virtual channels (VCs).
//
// Arbitration has two levels:
//   * Per VC, an input-level lock state. In IDLE a round-robin pointer
//     (rr_in) picks the first valid input at or after the pointer. A
//     granted non-tail flit locks the VC to that input until its tail has
//     been sent. This keeps a packet's flits contiguous on each VC.
//   * Across VCs, a round-robin pointer (rr_vc) picks one eligible VC per
//     cycle and moves past the winner, so flits of different VCs interleave.
//     A VC is eligible when it has a candidate flit and at least one
//     downstream credit.
//
// Handshake: a flit at (input i, VC v) moves exactly in a cycle where
// valid_i[i][v] && ready_o[i][v]. At most one ready_o bit is high per
// cycle. Once valid_i is raised it must stay high until ready_o. ready_o
// depends only on valid_i, last_i and internal state, never on data_i.
//
// Ports:
//   clk_i, rst_ni  clock; asynchronous active-low reset
//   valid_i        [NumInputs][NumVirtChannels] flit offered
//   ready_o        [NumInputs][NumVirtChannels] flit accepted this cycle
//   data_i         flit payload per input/VC
//   last_i         flit is packet tail
//   valid_o        registered: flit on link (one cycle after transfer)
//   vc_o           registered: VC of the link flit
//   data_o         registered: link flit payload
//   last_o         registered: link flit is tail
//   credit_i       one returned downstream credit per VC per cycle
module floo_credit_output_port #(
    parameter int unsigned NumInputs       = 4,
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned NumCredits      = 4,
    parameter type         flit_t          = logic,
    localparam int unsigned InW = (NumInputs > 1) ? $clog2(NumInputs) : 1,
    localparam int unsigned VcW = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1,
    localparam int unsigned CrW = $clog2(NumCredits + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NumInputs-1:0][NumVirtChannels-1:0] valid_i,
    output logic [NumInputs-1:0][NumVirtChannels-1:0] ready_o,
    input  flit_t                                     data_i [NumInputs][NumVirtChannels],
    input  logic [NumInputs-1:0][NumVirtChannels-1:0] last_i,
    output logic                                      valid_o,
    output logic [VcW-1:0]                            vc_o,
    output flit_t                                     data_o,
    output logic                                      last_o,
    input  logic [NumVirtChannels-1:0]                credit_i
);

    localparam logic [CrW-1:0] CreditMax = CrW'(NumCredits);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_e;

    // Per-VC lock state; owner is meaningful only while LOCKED.
    typedef struct packed {
        lock_e          mode;
        logic [InW-1:0] owner;
    } vc_state_t;

    vc_state_t      vc_state_q [NumVirtChannels];
    vc_state_t      vc_state_d [NumVirtChannels];
    logic [InW-1:0] rr_in_q    [NumVirtChannels];
    logic [InW-1:0] rr_in_d    [NumVirtChannels];
    logic [CrW-1:0] credit_q   [NumVirtChannels];
    logic [CrW-1:0] credit_d   [NumVirtChannels];
    logic [VcW-1:0] rr_vc_q, rr_vc_d;

    logic [InW-1:0]             cand_idx [NumVirtChannels];
    logic [NumVirtChannels-1:0] cand_valid;
    logic [NumVirtChannels-1:0] eligible;
    logic [NumVirtChannels-1:0] dec;
    logic                       xfer;
    logic [VcW-1:0]             sel_vc;
    logic [InW-1:0]             sel_in;
    logic                       sel_last;

    // Candidate input per VC. The round-robin scan walks k downwards so the
    // last hit, which wins, is the one closest to the pointer.
    always_comb begin
        int unsigned idx;
        idx = 0;
        for (int v = 0; v < int'(NumVirtChannels); v++) begin
            cand_valid[v] = 1'b0;
            cand_idx[v]   = '0;
            if (vc_state_q[v].mode == LOCKED) begin
                cand_idx[v]   = vc_state_q[v].owner;
                cand_valid[v] = valid_i[vc_state_q[v].owner][v];
            end else begin
                for (int k = int'(NumInputs) - 1; k >= 0; k--) begin
                    idx = 32'(rr_in_q[v]) + 32'(k);
                    if (idx >= NumInputs) idx = idx - NumInputs;
                    if (valid_i[idx[InW-1:0]][v]) begin
                        cand_valid[v] = 1'b1;
                        cand_idx[v]   = idx[InW-1:0];
                    end
                end
            end
            eligible[v] = cand_valid[v] && (credit_q[v] != '0);
        end
    end

    // VC selection and the one-hot ready. Reset forces ready_o low.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        sel_vc   = '0;
        for (int k = int'(NumVirtChannels) - 1; k >= 0; k--) begin
            idx = 32'(rr_vc_q) + 32'(k);
            if (idx >= NumVirtChannels) idx = idx - NumVirtChannels;
            if (eligible[idx[VcW-1:0]]) begin
                found  = 1'b1;
                sel_vc = idx[VcW-1:0];
            end
        end
        xfer     = found && rst_ni;
        sel_in   = cand_idx[sel_vc];
        sel_last = last_i[sel_in][sel_vc];
        ready_o  = '0;
        if (xfer) ready_o[sel_in][sel_vc] = 1'b1;
    end

    // Next state: lock/pointer update for the winning VC, credits for all.
    always_comb begin
        vc_state_d = vc_state_q;
        rr_in_d    = rr_in_q;
        rr_vc_d    = rr_vc_q;
        if (xfer) begin
            if (sel_last) begin
                vc_state_d[sel_vc] = '{mode: IDLE, owner: '0};
                rr_in_d[sel_vc]    = (sel_in == InW'(NumInputs - 1)) ? '0 : sel_in + 1'b1;
            end else begin
                vc_state_d[sel_vc] = '{mode: LOCKED, owner: sel_in};
            end
            rr_vc_d = (sel_vc == VcW'(NumVirtChannels - 1)) ? '0 : sel_vc + 1'b1;
        end
        for (int v = 0; v < int'(NumVirtChannels); v++) begin
            dec[v]      = xfer && (sel_vc == VcW'(v));
            credit_d[v] = credit_q[v];
            if (dec[v] && !credit_i[v]) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end else if (!dec[v] && credit_i[v] && (credit_q[v] != CreditMax)) begin
                // A surplus credit at full count is dropped, not wrapped.
                credit_d[v] = credit_q[v] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int v = 0; v < int'(NumVirtChannels); v++) begin
                vc_state_q[v] <= '{mode: IDLE, owner: '0};
                rr_in_q[v]    <= '0;
                credit_q[v]   <= CreditMax;
            end
            rr_vc_q <= '0;
            valid_o <= 1'b0;
            vc_o    <= '0;
            data_o  <= '0;
            last_o  <= 1'b0;
        end else begin
            vc_state_q <= vc_state_d;
            rr_in_q    <= rr_in_d;
            credit_q   <= credit_d;
            rr_vc_q    <= rr_vc_d;
            valid_o    <= xfer;
            last_o     <= xfer && sel_last;
            if (xfer) begin
                vc_o   <= sel_vc;
                data_o <= data_i[sel_in][sel_vc];
            end
        end
    end

    for (genvar gv = 0; gv < NumVirtChannels; gv++) begin : g_chk_vc
        a_credit_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
            credit_q[gv] <= CreditMax);
        a_credit_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(credit_i[gv] && (credit_q[gv] == CreditMax) && !dec[gv]));
        for (genvar gi = 0; gi < NumInputs; gi++) begin : g_chk_in
            a_valid_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
                valid_i[gi][gv] && !ready_o[gi][gv] |=> valid_i[gi][gv]);
        end
    end

endmodule

// File: tb/tb_floo_credit_output_port.sv
// Bench for floo_credit_output_port (4 inputs, 2 VCs, 4 credits, 8-bit
// flits). Flit payload is {input[1:0], vc, random[4:0]} so the order of
// grants can be read from data_o. A reference model at the falling edge
// predicts the grant from the arbitration rules, checks ready_o and queues
// the flit expected on the link one cycle later; a monitor pops and
// compares. Directed phases then inspect the observed flit log.
module tb_floo_credit_output_port;

    localparam int N  = 4;
    localparam int V  = 2;
    localparam int NC = 4;
    localparam int EW = 42; // {due_cycle[31:0], vc, last, data[7:0]}

    typedef logic [7:0] flit_t;

    logic                  clk;
    logic                  rst_n;
    logic [N-1:0][V-1:0]   valid_i;
    logic [N-1:0][V-1:0]   ready_o;
    flit_t                 data_i [N][V];
    logic [N-1:0][V-1:0]   last_i;
    logic                  valid_o;
    logic [0:0]            vc_o;
    flit_t                 data_o;
    logic                  last_o;
    logic [V-1:0]          credit_i;

    floo_credit_output_port #(
        .NumInputs      (N),
        .NumVirtChannels(V),
        .NumCredits     (NC),
        .flit_t         (flit_t)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .vc_o    (vc_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .credit_i(credit_i)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc;
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // ---------------- bench state ----------------
    int             pkt_left [N][V]; // flits left in the current packet
    int             gen_mode;        // 0 directed, 1 random, 2 single flits on VC0
    int             cred_mode;       // 0 manual pulses, 1 random, 2 return at once
    logic [V-1:0]   cred_pulse;
    int             g_i, g_v;        // grant predicted for the coming edge
    int             m_owner [V];     // -1 idle, else locked input
    int             m_rr_in [V];
    int             m_rr_vc;
    int             m_cred  [V];
    logic [EW-1:0]  exp_q[$];
    flit_t          obs_q[$];
    int             vectors;
    int             miscompares;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++)
            for (int v = 0; v < V; v++) pkt_left[i][v] = 0;
        for (int v = 0; v < V; v++) begin
            m_owner[v] = -1;
            m_rr_in[v] = 0;
            m_cred[v]  = NC;
        end
        m_rr_vc    = 0;
        gen_mode   = 0;
        cred_mode  = 0;
        cred_pulse = '0;
        g_i        = -1;
        g_v        = -1;
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- driver ----------------
    task automatic drive_step();
        bit granted;
        bit hold;
        for (int i = 0; i < N; i++) begin
            for (int v = 0; v < V; v++) begin
                granted = (g_i == i) && (g_v == v);
                if (granted && pkt_left[i][v] > 0) pkt_left[i][v]--;
                if (gen_mode == 1 && pkt_left[i][v] == 0 && $urandom_range(0, 3) == 0)
                    pkt_left[i][v] = $urandom_range(1, 4);
                if (gen_mode == 2 && v == 0 && pkt_left[i][v] == 0)
                    pkt_left[i][v] = 1;
                hold          = valid_i[i][v] && !granted;
                valid_i[i][v] = (pkt_left[i][v] > 0);
                last_i[i][v]  = (pkt_left[i][v] == 1);
                if (!hold) data_i[i][v] = {2'(i), 1'(v), 5'($urandom)};
            end
        end
        g_i = -1;
        g_v = -1;
        for (int v = 0; v < V; v++) begin
            case (cred_mode)
                1:       credit_i[v] = (m_cred[v] < NC) && ($urandom_range(0, 2) == 0);
                2:       credit_i[v] = (m_cred[v] < NC);
                default: credit_i[v] = cred_pulse[v];
            endcase
        end
        cred_pulse = '0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            drive_step();
        end
    end

    // ---------------- reference model ----------------
    task automatic model_step();
        int                  cand [V];
        int                  sel;
        int                  ii;
        int                  vv;
        logic [N-1:0][V-1:0] exp_ready;
        logic [EW-1:0]       e;
        for (int v = 0; v < V; v++) begin
            cand[v] = -1;
            if (m_owner[v] >= 0) begin
                if (valid_i[m_owner[v]][v]) cand[v] = m_owner[v];
            end else begin
                for (int k = 0; k < N; k++) begin
                    ii = (m_rr_in[v] + k) % N;
                    if (cand[v] < 0 && valid_i[ii][v]) cand[v] = ii;
                end
            end
        end
        sel = -1;
        for (int k = 0; k < V; k++) begin
            vv = (m_rr_vc + k) % V;
            if (sel < 0 && cand[vv] >= 0 && m_cred[vv] > 0) sel = vv;
        end
        exp_ready = '0;
        if (sel >= 0) exp_ready[cand[sel]][sel] = 1'b1;
        check("ready_o", int'(ready_o), int'(exp_ready));
        if (sel >= 0) begin
            e = {32'(cyc + 1), 1'(sel), last_i[cand[sel]][sel], data_i[cand[sel]][sel]};
            exp_q.push_back(e);
            if (last_i[cand[sel]][sel]) begin
                m_owner[sel] = -1;
                m_rr_in[sel] = (cand[sel] + 1) % N;
            end else begin
                m_owner[sel] = cand[sel];
            end
            m_rr_vc      = (sel + 1) % V;
            m_cred[sel]  = m_cred[sel] - 1;
            g_i          = cand[sel];
            g_v          = sel;
        end
        for (int v = 0; v < V; v++) begin
            if (credit_i[v]) m_cred[v] = (m_cred[v] + 1 > NC) ? NC : m_cred[v] + 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (exp_q.size() > 0 && exp_q[0][41:10] == 32'(cyc)) begin
                    e = exp_q.pop_front();
                    check("out_flit", int'({valid_o, vc_o, last_o, data_o}),
                          int'({1'b1, e[9:0]}));
                end else begin
                    check("out_idle", int'(valid_o), 0);
                end
                if (valid_o) obs_q.push_back(data_o);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        clear_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_obs(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #2;
        check(name, (obs_q.size() >= n) ? 1 : 0, 1);
    endtask

    function automatic int obs_in(input int k);
        flit_t d;
        d = obs_q[k];
        return int'(d[7:6]);
    endfunction

    function automatic int obs_vc(input int k);
        flit_t d;
        d = obs_q[k];
        return int'(d[5]);
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int sum;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        valid_i     = '0;
        last_i      = '0;
        credit_i    = '0;
        for (int i = 0; i < N; i++)
            for (int v = 0; v < V; v++) data_i[i][v] = '0;
        clear_all();

        // Reset state with traffic offered.
        pkt_left[0][0] = 3;
        pkt_left[2][1] = 1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_ready_o", int'(ready_o), 0);
        check("rst_valid_o", int'(valid_o), 0);
        check("rst_vc_o", int'(vc_o), 0);
        check("rst_data_o", int'(data_o), 0);
        check("rst_last_o", int'(last_o), 0);
        clear_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Two 3-flit packets on VC0 stay contiguous; rr_in[0] ends at 3.
        do_reset();
        cred_mode = 2;
        @(posedge clk);
        pkt_left[0][0] = 3;
        pkt_left[2][0] = 3;
        wait_obs("pkt_done", 6, 60);
        for (int k = 0; k < 6; k++) check("pkt_order", obs_in(k), (k < 3) ? 0 : 2);
        @(posedge clk);
        pkt_left[1][0] = 1;
        pkt_left[3][0] = 1;
        wait_obs("rr_done", 8, 30);
        check("rr_first", obs_in(6), 3);
        check("rr_second", obs_in(7), 1);

        // Credit exhaustion on VC1, then a single returned credit.
        do_reset();
        @(posedge clk);
        pkt_left[0][1] = 6;
        wait_cycles(12);
        check("cred_count", obs_q.size(), 4);
        sum = 0;
        for (int k = 0; k < obs_q.size(); k++) sum += obs_vc(k);
        check("cred_vc", sum, 4);
        check("cred_blocked", int'(ready_o[0][1]), 0);
        @(posedge clk);
        cred_pulse[1] = 1'b1;
        wait_cycles(6);
        check("cred_one_more", obs_q.size(), 5);

        // Flit-level VC interleaving.
        do_reset();
        cred_mode = 2;
        @(posedge clk);
        pkt_left[0][0] = 8;
        pkt_left[1][1] = 8;
        wait_obs("alt_done", 8, 40);
        for (int k = 0; k < 8; k++) check("vc_alternate", obs_vc(k), k % 2);

        // Transfer and credit return in the same cycle at credit 2.
        do_reset();
        @(posedge clk);
        pkt_left[1][0] = 2;
        wait_cycles(6);
        check("same_cyc_pre", obs_q.size(), 2);
        @(posedge clk);
        pkt_left[2][0] = 1;
        cred_pulse[0]  = 1'b1;
        wait_cycles(4);
        check("same_cyc_xfer", obs_q.size(), 3);
        @(posedge clk);
        pkt_left[3][0] = 4;
        wait_cycles(10);
        check("same_cyc_credit2", obs_q.size(), 5);

        // Reset in the middle of a packet drops the lock and restores credits.
        do_reset();
        @(posedge clk);
        pkt_left[1][0] = 4;
        wait_obs("mid_head", 1, 10);
        check("mid_head_in", obs_in(0), 1);
        do_reset();
        @(posedge clk);
        pkt_left[3][0] = 5;
        wait_cycles(12);
        check("post_rst_count", obs_q.size(), 4);
        check("post_rst_in", obs_in(0), 3);

        // Back-to-back single-flit packets from every input on VC0.
        do_reset();
        cred_mode = 2;
        gen_mode  = 2;
        wait_obs("single_done", 5, 20);
        for (int k = 0; k < 5; k++) check("single_order", obs_in(k), k % N);
        gen_mode = 0;

        // Random traffic and random credit return, then drain.
        do_reset();
        gen_mode  = 1;
        cred_mode = 1;
        wait_cycles(3000);
        gen_mode  = 0;
        cred_mode = 2;
        wait_cycles(120);
        sum = 0;
        for (int i = 0; i < N; i++)
            for (int v = 0; v < V; v++) sum += pkt_left[i][v];
        check("drain_sources", sum, 0);
        check("drain_expected", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
